regfile_write_ctrl: RTL and testbench

- Write-side controller for the 32-entry register file.
- Collects write-back requests from two producers, the ALU result path and the load/memory path, each with a valid/ready handshake.
- Buffers requests in a small in-order FIFO and issues at most one register-file write per cycle on the Reg_Write / Write_Register / Write_Data interface.
- Exports a pending-write busy mask so decode can detect read-after-write hazards.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 74 +++++++
 rtl/regfile_write_ctrl.sv | 95 +++++++++
 tb/tb_regfile_write_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // One write-back request as seen by the arbiter. Data is XLEN wide, so
  // the controller's WIDTH must not exceed XLEN.
  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // One-hot register select, used to build the pending-write mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter register. Exposes
// a per-slot valid/address view so the owner can build a busy mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push,
  input  reg_addr_t                           push_addr,
  input  logic [WIDTH-1:0]                    push_data,
  input  logic                                pop,
  input  logic                                flush,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(DEPTH):0]              count,
  output reg_addr_t                           head_addr,
  output logic [WIDTH-1:0]                    head_data,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                         wptr, rptr;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]    addr_q;
  logic [DEPTH-1:0][WIDTH-1:0]         data_q;
  logic                                do_push, do_pop;

  // Protect the pointers against overflow/underflow; flush overrides both.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count = wptr - rptr;

  assign head_addr = addr_q[rptr[AW-1:0]];
  assign head_data = data_q[rptr[AW-1:0]];
  assign ent_addr  = addr_q;

  // Pointer update: flush rewinds both pointers, otherwise each advances on its own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Entry storage; contents only matter while the slot is marked valid.
  always_ff @(posedge clock) begin
    if (do_push && reset) begin
      addr_q[wptr[AW-1:0]] <= push_addr;
      data_q[wptr[AW-1:0]] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [AW-1:0] off;
    assign off        = AW'(i) - rptr[AW-1:0];
    assign ent_vld[i] = ({1'b0, off} < count);
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-side controller for the 32-entry register file. Arbitrates the ALU
// and load producers (ALU wins), drops writes to r0, buffers the rest in
// order and issues at most one register-file write per cycle.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alu_valid_i,
  output logic                        alu_ready_o,
  input  logic [REG_ADDR_W-1:0]       alu_addr_i,
  input  logic [WIDTH-1:0]            alu_data_i,
  input  logic                        mem_valid_i,
  output logic                        mem_ready_o,
  input  logic [REG_ADDR_W-1:0]       mem_addr_i,
  input  logic [WIDTH-1:0]            mem_data_i,
  input  logic                        wb_stall_i,
  input  logic                        flush_i,
  output logic                        Reg_Write_o,
  output logic [REG_ADDR_W-1:0]       Write_Register_o,
  output logic [WIDTH-1:0]            Write_Data_o,
  output logic [NUM_REGS-1:0]         busy_mask_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  logic                               full, empty;
  logic                               alu_fire, mem_fire, push, pop;
  wb_req_t                            sel;
  reg_addr_t                          head_addr;
  logic [WIDTH-1:0]                   head_data;
  logic [DEPTH-1:0]                   ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_addr;

  // Ready looks only at fullness, never at a same-cycle pop, to keep the
  // handshake off the stall/flush timing path.
  assign alu_ready_o = !full;
  assign mem_ready_o = !full && !alu_valid_i;

  assign alu_fire = alu_valid_i && alu_ready_o;
  assign mem_fire = mem_valid_i && mem_ready_o;

  // Fixed-priority select: ALU request when present, otherwise load.
  always_comb begin
    sel.addr = mem_addr_i;
    sel.data = XLEN'(mem_data_i);
    if (alu_valid_i) begin
      sel.addr = alu_addr_i;
      sel.data = XLEN'(alu_data_i);
    end
  end

  // r0 writes complete the handshake but are never buffered; a push in a
  // flush cycle is dropped.
  assign push = (alu_fire || mem_fire) && (sel.addr != ZERO_REG) && !flush_i;

  assign Reg_Write_o = !empty && !wb_stall_i && !flush_i;
  assign pop         = Reg_Write_o;

  assign Write_Register_o = empty ? ZERO_REG : head_addr;
  assign Write_Data_o     = empty ? '0       : head_data;

  wb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_addr (sel.addr),
    .push_data (sel.data[WIDTH-1:0]),
    .pop       (pop),
    .flush     (flush_i),
    .full      (full),
    .empty     (empty),
    .count     (count_o),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr)
  );

  // Busy mask: OR of one-hot destinations over live slots; the head stays
  // counted through its issue cycle. Bit 0 is forced low.
  always_comb begin
    busy_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) busy_mask_o = busy_mask_o | reg_onehot(ent_addr[i]);
    end
    busy_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: a queue model of the buffered
// writes is updated at each rising edge from the driven stimulus and
// compared against the DUT outputs on every falling edge.
module tb_regfile_write_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clock = 0;
  logic        reset = 0;
  logic        alu_valid_i = 0, mem_valid_i = 0;
  logic        alu_ready_o, mem_ready_o;
  logic [4:0]  alu_addr_i = 0, mem_addr_i = 0;
  logic [31:0] alu_data_i = 0, mem_data_i = 0;
  logic        wb_stall_i = 0, flush_i = 0;
  logic        Reg_Write_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o;
  logic [31:0] busy_mask_o;
  logic [2:0]  count_o;

  regfile_write_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .alu_valid_i      (alu_valid_i),
    .alu_ready_o      (alu_ready_o),
    .alu_addr_i       (alu_addr_i),
    .alu_data_i       (alu_data_i),
    .mem_valid_i      (mem_valid_i),
    .mem_ready_o      (mem_ready_o),
    .mem_addr_i       (mem_addr_i),
    .mem_data_i       (mem_data_i),
    .wb_stall_i       (wb_stall_i),
    .flush_i          (flush_i),
    .Reg_Write_o      (Reg_Write_o),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o),
    .busy_mask_o      (busy_mask_o),
    .count_o          (count_o)
  );

  always #5 clock = ~clock;

  int          n_chk = 0, n_pass = 0;
  bit          mon_en = 0;
  ent_t        q[$];
  logic [4:0]  wlog[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Reference model: apply the edge using the inputs that were stable before it.
  always @(posedge clock) begin
    if (reset) begin
      bit   full, acc, pop;
      ent_t e;
      full = (q.size() == DEPTH);
      pop  = (q.size() > 0) && !wb_stall_i && !flush_i;
      acc  = 0;
      if (alu_valid_i && !full) begin
        acc = 1; e.addr = alu_addr_i; e.data = alu_data_i;
      end else if (mem_valid_i && !full && !alu_valid_i) begin
        acc = 1; e.addr = mem_addr_i; e.data = mem_data_i;
      end
      if (flush_i) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc && e.addr != 5'd0) q.push_back(e);
      end
    end
  end

  // Output monitor: compare every output against the model mid-cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("reg_write", Reg_Write_o, (q.size() > 0) && !wb_stall_i && !flush_i);
      chk("count",     count_o,     q.size());
      chk("busy_mask", busy_mask_o, model_mask());
      chk("alu_ready", alu_ready_o, q.size() < DEPTH);
      chk("mem_ready", mem_ready_o, (q.size() < DEPTH) && !alu_valid_i);
      if (q.size() > 0) begin
        chk("wr_addr", Write_Register_o, q[0].addr);
        chk("wr_data", Write_Data_o,     q[0].data);
      end else begin
        chk("wr_addr_idle", Write_Register_o, 0);
        chk("wr_data_idle", Write_Data_o,     0);
      end
      if (Reg_Write_o) wlog.push_back(Write_Register_o);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle();
    alu_valid_i = 0; mem_valid_i = 0; wb_stall_i = 0; flush_i = 0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    alu_valid_i = 1; alu_addr_i = a; alu_data_i = d;
  endtask

  task automatic chk_log(input string tag, input logic [4:0] exp[$]);
    chk({tag, "_len"}, wlog.size(), exp.size());
    foreach (exp[i]) if (i < wlog.size()) chk(tag, wlog[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    // Reset held: FIFO empty, both producers see ready.
    cyc(2);
    chk("rst_alu_ready", alu_ready_o, 1);
    chk("rst_mem_ready", mem_ready_o, 1);
    chk("rst_count",     count_o,     0);
    chk("rst_reg_write", Reg_Write_o, 0);
    reset = 1;
    mon_en = 1;
    cyc(2);

    // Single ALU write into an empty FIFO.
    wlog.delete();
    alu(5'd5, 32'hDEADBEEF);
    cyc();
    idle();
    @(negedge clock);
    chk("t1_reg_write", Reg_Write_o,      1);
    chk("t1_addr",      Write_Register_o, 5);
    chk("t1_data",      Write_Data_o,     32'hDEADBEEF);
    chk("t1_mask",      busy_mask_o,      32'h20);
    cyc();
    @(negedge clock);
    chk("t1_after_rw",   Reg_Write_o, 0);
    chk("t1_after_mask", busy_mask_o, 0);
    cyc();

    // ALU and load together: ALU first, load the cycle after.
    wlog.delete();
    alu(5'd3, 32'd1);
    mem_valid_i = 1; mem_addr_i = 5'd4; mem_data_i = 32'd2;
    @(negedge clock);
    chk("t2_mem_blocked", mem_ready_o, 0);
    cyc();
    alu_valid_i = 0;
    @(negedge clock);
    chk("t2_mem_ready", mem_ready_o, 1);
    cyc();
    idle();
    cyc(3);
    chk_log("t2_order", '{5'd3, 5'd4});

    // Stall to fill, then drain with a new push after the first pop.
    wlog.delete();
    wb_stall_i = 1;
    for (int i = 1; i <= 4; i++) begin
      alu(5'(i), 32'h100 + i);
      cyc();
    end
    alu(5'd6, 32'h66);
    @(negedge clock);
    chk("t3_count", count_o,     4);
    chk("t3_alu_r", alu_ready_o, 0);
    chk("t3_mask",  busy_mask_o, 32'h1E);
    wb_stall_i = 0;
    cyc(2);
    alu_valid_i = 0;
    cyc(6);
    chk_log("t3_order", '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6});

    // r0 request is acknowledged and dropped; r7 is written.
    wlog.delete();
    alu(5'd0, 32'hFFFF);
    @(negedge clock);
    chk("t4_r0_ready", alu_ready_o, 1);
    cyc();
    alu(5'd7, 32'd9);
    @(negedge clock);
    chk("t4_r0_count", count_o, 0);
    cyc();
    idle();
    cyc(3);
    chk_log("t4_only_r7", '{5'd7});

    // Ten back-to-back writes through the ring.
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      if (i[0]) begin
        alu_valid_i = 0;
        mem_valid_i = 1; mem_addr_i = 5'(8 + i); mem_data_i = $urandom;
      end else begin
        mem_valid_i = 0;
        alu(5'(8 + i), $urandom);
      end
      cyc();
    end
    idle();
    cyc(3);
    chk_log("t5_stream", '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17});

    // Flush with two pending (and a push in the flush cycle).
    wlog.delete();
    wb_stall_i = 1;
    alu(5'd20, 32'h20); cyc();
    alu(5'd21, 32'h21); cyc();
    alu(5'd22, 32'h22); flush_i = 1;
    cyc();
    idle();
    @(negedge clock);
    chk("t6_mask",  busy_mask_o, 0);
    chk("t6_count", count_o,     0);
    cyc(3);
    chk("t6_no_writes", wlog.size(), 0);

    // Randomised traffic with stalls and occasional flushes.
    for (int i = 0; i < 80; i++) begin
      alu_valid_i = ($urandom_range(0, 99) < 50);
      alu_addr_i  = 5'($urandom_range(0, 7));
      alu_data_i  = $urandom;
      mem_valid_i = ($urandom_range(0, 99) < 50);
      mem_addr_i  = 5'($urandom_range(0, 7));
      mem_data_i  = $urandom;
      wb_stall_i  = ($urandom_range(0, 99) < 35);
      flush_i     = ($urandom_range(0, 99) < 5);
      cyc();
    end
    idle();

    // Reset mid-stream with three entries buffered.
    wb_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      alu(5'(24 + i), 32'hA0 + i);
      cyc();
    end
    alu_valid_i = 0;
    #2;
    reset = 0;
    q.delete();
    #1;
    chk("t7_count",     count_o,     0);
    chk("t7_reg_write", Reg_Write_o, 0);
    chk("t7_mask",      busy_mask_o, 0);
    alu(5'd9, 32'h99);
    cyc(2);
    alu_valid_i = 0;
    reset = 1;
    wb_stall_i = 0;
    @(negedge clock);
    chk("t7_alu_ready", alu_ready_o, 1);
    chk("t7_count_rel", count_o,     0);
    cyc(2);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
